serial_frame_tx: RTL and testbench
==================================

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter PRE_W, default 4, preamble length in bits.
REQ-002 Parameter PRE, default 4'b1101, preamble pattern sent MSB first.
REQ-003 Parameter LEN_W, default 4, width of the length field; maximum payload is 2^LEN_W-1 bits.
REQ-004 Parameter DATA_W, default 16, payload register width; DATA_W SHALL be >= 2^LEN_W-1.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  frame request, sampled on clk.
REQ-008 port  input  2  destination port field.
REQ-009 len  input  LEN_W  payload bit count L.
REQ-010 data_in  input  DATA_W  payload; bits [L-1:0] are sent.
REQ-011 ser_out  output  1  serial line, registered; 0 when idle.
REQ-012 ser_valid  output  1  high while ser_out carries a frame bit.
REQ-013 busy  output  1  high from the cycle after start is accepted through the last frame bit.
REQ-014 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-015 The FSM SHALL have states IDLE, PRE, HDR, PAY and DONE.
REQ-016 In IDLE or DONE, a sampled start=1 SHALL capture port, len and data_in into internal registers and move to PRE.
REQ-017 start SHALL be ignored in PRE, HDR and PAY.
REQ-018 Input changes after capture SHALL NOT affect the frame in flight.
REQ-019 The first preamble bit SHALL appear on ser_out in the cycle after the accepting edge, giving 1 cycle latency.
REQ-020 PRE SHALL emit PRE[PRE_W-1] down to PRE[0], one bit per cycle, PRE_W cycles.
REQ-021 HDR SHALL emit port[1], port[0], then len MSB first, for 2+LEN_W cycles.
REQ-022 PAY SHALL emit data bits [0] up to [L-1], LSB first, for L cycles.
REQ-023 If L=0, HDR SHALL go directly to DONE with no PAY cycles.
REQ-024 Cycle counting SHALL use a down-counter loaded on each state entry; the state advances when the count reaches its terminal value.
REQ-025 Total frame length SHALL be PRE_W+2+LEN_W+L cycles; busy and ser_valid SHALL be high exactly during those cycles.
REQ-026 DONE SHALL last one cycle.
REQ-027 In DONE: done=1, busy=0, ser_valid=0, ser_out=0.
REQ-028 DONE SHALL go to PRE if start=1 (back-to-back frames with no gap bit), else to IDLE.
REQ-029 In IDLE: ser_out=0, ser_valid=0, busy=0, done=0.
REQ-030 Unused or illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, clear counters and capture registers, and drive ser_out, ser_valid, busy and done to 0, regardless of the current clk.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse.
REQ-033 After reset release, the first start SHALL be handled exactly as from IDLE.

Verification
REQ-034 Bench: hold rst=1, toggle start/inputs -> all outputs 0; release -> outputs stay 0 until start.
REQ-035 Bench: port=2'b10, len=3, data_in=16'h0005, start pulse -> ser_out = 1101 10 0011 101 over 13 cycles with ser_valid=busy=1, then done=1 for 1 cycle.
REQ-036 Bench: len=0, port=2'b01 -> 1101 01 0000 (10 bits), then done; no payload cycles.
REQ-037 Bench: start held high and port/len/data changed during a len=5 frame -> frame bits unchanged; second frame's preamble starts the cycle after the DONE cycle; done pulses once per frame.
REQ-038 Bench: rst pulsed asynchronously (between clk edges) during PAY -> outputs 0 within the same cycle; no done; next start yields a complete correct frame.
REQ-039 Bench: len=15, data_in=16'h7FFF -> 25-bit frame ending in fifteen 1s; busy high exactly 25 cycles.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble, port/length header, LSB-first payload.
// Registered outputs; frames may run back-to-back with no gap bit.
module serial_frame_tx #(
  parameter int               PRE_W  = 4,
  parameter logic [PRE_W-1:0] PRE    = 4'b1101,
  parameter int               LEN_W  = 4,
  parameter int               DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        port,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done
);

  localparam int HDR_W = LEN_W + 2;
  localparam int PAY_M = (1 << LEN_W) - 1;
  localparam int M1    = (PRE_W > HDR_W) ? PRE_W : HDR_W;
  localparam int MAXC  = (M1 > PAY_M) ? M1 : PAY_M;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE_S = 3'd1,
    HDR = 3'd2,
    PAY = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PRE_W-1:0]   pre_q;
  logic [HDR_W-1:0]   hdr_q;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  data_q;
  logic               ser_out_q;
  logic               ser_valid_q;
  logic               busy_q;
  logic               done_q;

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Outputs are computed one edge early so each bit lands registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pre_q       <= '0;
      hdr_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= PRE_S;
            cnt_q       <= CNT_W'(PRE_W - 1);
            pre_q       <= PRE << 1;
            hdr_q       <= {port, len};
            len_q       <= len;
            data_q      <= data_in;
            ser_out_q   <= PRE[PRE_W-1];
            ser_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end else begin
            state_q     <= IDLE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        PRE_S: begin
          if (cnt_q == '0) begin
            state_q   <= HDR;
            cnt_q     <= CNT_W'(HDR_W - 1);
            ser_out_q <= hdr_q[HDR_W-1];
            hdr_q     <= {hdr_q[HDR_W-2:0], 1'b0};
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            ser_out_q <= pre_q[PRE_W-1];
            pre_q     <= pre_q << 1;
          end
        end
        HDR: begin
          if (cnt_q != '0) begin
            cnt_q     <= cnt_q - 1'b1;
            ser_out_q <= hdr_q[HDR_W-1];
            hdr_q     <= {hdr_q[HDR_W-2:0], 1'b0};
          end else if (len_q == '0) begin
            state_q     <= DONE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            state_q   <= PAY;
            cnt_q     <= CNT_W'(len_q) - 1'b1;
            ser_out_q <= data_q[0];
            data_q    <= data_q >> 1;
          end
        end
        PAY: begin
          if (cnt_q == '0) begin
            state_q     <= DONE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            ser_out_q <= data_q[0];
            data_q    <= data_q >> 1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx; a scoreboard queue holds expected bits
// pushed at frame request and popped as ser_valid bits appear.
module tb_serial_frame_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  port;
  logic [3:0]  len;
  logic [15:0] data_in;
  logic        ser_out;
  logic        ser_valid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int bitcnt = 0;
  logic done_prev = 1'b0;
  logic exp_q[$];
  int   explen_q[$];

  serial_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .port     (port),
    .len      (len),
    .data_in  (data_in),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [1:0] p, input int l,
                            input logic [15:0] d);
    logic [3:0] pre_bits;
    logic [3:0] lb;
    pre_bits = 4'b1101;
    lb = 4'(l);
    for (int i = 3; i >= 0; i--) exp_q.push_back(pre_bits[i]);
    exp_q.push_back(p[1]);
    exp_q.push_back(p[0]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(lb[i]);
    for (int i = 0; i < l; i++) exp_q.push_back(d[i]);
    explen_q.push_back(10 + l);
  endtask

  // Accept one frame, check 1-cycle latency, then scramble inputs
  task automatic send(input logic [1:0] p, input int l,
                      input logic [15:0] d);
    @(posedge clk) #1;
    start = 1'b1;
    port = p;
    len = 4'(l);
    data_in = d;
    push_frame(p, l, d);
    @(posedge clk) #1;
    start = 1'b0;
    chk("latency", {busy, ser_valid, ser_out}, 3'b111);
    port = 2'($urandom);
    len = 4'($urandom);
    data_in = 16'($urandom);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_seen < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("done_wait", done_seen, target);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      explen_q.delete();
      bitcnt = 0;
      chk("rst_out", {ser_out, ser_valid, busy, done}, 0);
    end else begin
      if (ser_valid) begin
        chk("valid_busy", busy, 1);
        chk("bit_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("bit", ser_out, exp_q.pop_front());
        bitcnt++;
      end else begin
        chk("idle_out", {ser_out, busy}, 0);
      end
      if (done) begin
        done_seen++;
        chk("len_pending", explen_q.size() > 0, 1);
        if (explen_q.size() > 0)
          chk("frame_len", bitcnt, explen_q.pop_front());
        bitcnt = 0;
      end
      chk("done_1cyc", done & done_prev, 0);
    end
    done_prev = done;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    rst = 1'b1;
    start = 1'b0;
    port = '0;
    len = '0;
    data_in = '0;
    repeat (4) begin
      @(posedge clk) #1;
      start = ~start;
      port = 2'($urandom);
      len = 4'($urandom);
      data_in = 16'($urandom);
      chk("rst_hold", {ser_out, ser_valid, busy, done}, 0);
    end
    #2 rst = 1'b0;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", {ser_out, ser_valid, busy, done}, 0);

    send(2'b10, 3, 16'h0005);
    wait_done(1);
    send(2'b01, 0, 16'hFFFF);
    wait_done(2);
    chk("q_drained_a", exp_q.size(), 0);

    // Start held through frame; inputs changed mid-frame
    @(posedge clk) #1;
    start = 1'b1;
    port = 2'b11;
    len = 4'd5;
    data_in = 16'h0016;
    push_frame(2'b11, 5, 16'h0016);
    @(posedge clk) #1;
    port = 2'b01;
    len = 4'd2;
    data_in = 16'h0002;
    push_frame(2'b01, 2, 16'h0002);
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(posedge clk) #1;
      t++;
    end
    chk("b2b_done", done, 1);
    @(posedge clk) #1;
    start = 1'b0;
    chk("no_gap", {busy, ser_valid, ser_out}, 3'b111);
    wait_done(4);
    repeat (3) @(posedge clk);
    #1 chk("b2b_stop", {busy, done_seen}, {1'b0, 31'd4});
    chk("q_drained_b", exp_q.size(), 0);

    // Asynchronous reset in the payload
    send(2'b11, 8, 16'hA5C3);
    repeat (11) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_rst", {ser_out, ser_valid, busy, done}, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("abort_no_done", done_seen, 4);

    send(2'b00, 15, 16'h7FFF);
    wait_done(5);
    chk("q_drained_c", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 chk("final_idle", {ser_out, ser_valid, busy, done}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
